frame_buf_replay: RTL and testbench



---
 rtl/frame_buf_replay.sv | 239 +++++++++++++++++++++++
 tb/tb_frame_buf_replay.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buf_replay.sv
// Single-frame capture/replay buffer: one pixel-byte stream is captured into a dual-port RAM
// and replayed forward or group-reversed; host port B has independent access to the same RAM.
module frame_buf_replay #(
    parameter int DW  = 8,
    parameter int AW  = 18,
    parameter int GRP = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic          in_sof,
    input  logic          in_eof,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [AW:0]   frame_len,
    output logic          ovf,
    output logic          busy,
    input  logic          hb_en,
    input  logic          hb_we,
    input  logic [AW-1:0] hb_addr,
    input  logic [DW-1:0] hb_din,
    output logic [DW-1:0] hb_dout
);
    localparam int            KW      = 4;
    localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH_W = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   GRP_W   = (AW+1)'(GRP);
    localparam logic [KW-1:0] K_ONE   = KW'(1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_REPLAY, S_DRAIN} state_t;
    state_t state, state_d;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] ram_a_q;
    logic [AW-1:0] a_addr, cap_addr, rd_addr, grp_addr;
    logic [AW:0]   wr_ptr, len_next, rd_cnt, gbase, gbase_nx;
    logic [KW-1:0] k_down;
    logic          wr_full, mode_q;
    logic          cap_we, cap_start, cap_end, cap_ovf;
    logic          rd_issue, rd_is_last, rd_pending, rd_pend_last, slot_free;
    logic          push, pop;
    logic [1:0]    buf_cnt;
    logic [2:0]    occ;
    logic [DW-1:0] buf_data0, buf_data1;
    logic          buf_last0, buf_last1;

    // Last element index of a group holding min(GRP, remaining) elements.
    function automatic logic [KW-1:0] grp_last_k(input logic [AW:0] remaining);
        if (remaining < GRP_W) return KW'(remaining - LEN_ONE);
        return KW'(GRP - 1);
    endfunction

    assign wr_full    = wr_ptr[AW];
    assign gbase_nx   = gbase + GRP_W;
    assign grp_addr   = gbase[AW-1:0] + AW'(k_down);
    assign rd_addr    = mode_q ? grp_addr : rd_cnt[AW-1:0];
    assign rd_is_last = (rd_cnt == frame_len - LEN_ONE);
    assign a_addr     = (state == S_REPLAY) ? rd_addr : cap_addr;

    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = buf_data0;
    assign out_last  = buf_last0 & out_valid;
    assign pop       = out_valid & out_ready;
    assign push      = rd_pending;
    assign in_ready  = (state == S_IDLE) || (state == S_CAPTURE);
    assign busy      = (state != S_IDLE);

    // Buffered beats plus the read in flight, after this cycle's pop, must leave a free slot.
    assign occ       = 3'(buf_cnt) + 3'(rd_pending) - 3'(pop);
    assign slot_free = (occ < 3'd2);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // NOTE: every output of this block is given a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state;
        cap_we    = 1'b0;
        cap_addr  = wr_ptr[AW-1:0];
        cap_start = 1'b0;
        cap_end   = 1'b0;
        cap_ovf   = 1'b0;
        rd_issue  = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && in_sof) begin
                    cap_we    = 1'b1;
                    cap_addr  = '0;
                    cap_start = 1'b1;
                    if (in_eof) begin
                        cap_end = 1'b1;
                        state_d = S_REPLAY;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (in_valid) begin
                    if (in_sof) begin
                        cap_we    = 1'b1;
                        cap_addr  = '0;
                        cap_start = 1'b1;
                    end else if (wr_full) begin
                        cap_ovf = 1'b1;
                    end else begin
                        cap_we = 1'b1;
                    end
                    if (in_eof) begin
                        cap_end = 1'b1;
                        state_d = S_REPLAY;
                    end
                end
            end
            S_REPLAY: begin
                if (slot_free) begin
                    rd_issue = 1'b1;
                    if (rd_is_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && out_last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        if (cap_start)    len_next = LEN_ONE;
        else if (wr_full) len_next = DEPTH_W;
        else              len_next = wr_ptr + LEN_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            ovf          <= 1'b0;
            frame_len    <= '0;
            mode_q       <= 1'b0;
            rd_cnt       <= '0;
            gbase        <= '0;
            k_down       <= '0;
            rd_pending   <= 1'b0;
            rd_pend_last <= 1'b0;
        end else begin
            if (cap_start) begin
                wr_ptr <= LEN_ONE;
                ovf    <= 1'b0;
            end else if (cap_we) begin
                wr_ptr <= wr_ptr + LEN_ONE;
            end
            if (cap_ovf) ovf <= 1'b1;
            if (cap_end) begin
                frame_len <= len_next;
                mode_q    <= mode;
                rd_cnt    <= '0;
                gbase     <= '0;
                k_down    <= grp_last_k(len_next);
            end else if (rd_issue) begin
                rd_cnt <= rd_cnt + LEN_ONE;
                if (k_down == '0) begin
                    gbase  <= gbase_nx;
                    k_down <= grp_last_k(frame_len - gbase_nx);
                end else begin
                    k_down <= k_down - K_ONE;
                end
            end
            rd_pending   <= rd_issue;
            rd_pend_last <= rd_issue & rd_is_last;
        end
    end

    // Two-entry output skid buffer; entry 0 drives the output and holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt   <= 2'd0;
            buf_data0 <= '0;
            buf_data1 <= '0;
            buf_last0 <= 1'b0;
            buf_last1 <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        buf_data0 <= ram_a_q;
                        buf_last0 <= rd_pend_last;
                    end else begin
                        buf_data1 <= ram_a_q;
                        buf_last1 <= rd_pend_last;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    if (buf_cnt == 2'd2) begin
                        buf_data0 <= buf_data1;
                        buf_last0 <= buf_last1;
                    end
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf_data0 <= ram_a_q;
                        buf_last0 <= rd_pend_last;
                    end else begin
                        buf_data0 <= buf_data1;
                        buf_last0 <= buf_last1;
                        buf_data1 <= ram_a_q;
                        buf_last1 <= rd_pend_last;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the RAM array has no reset, so its contents survive rst_n and it maps onto
    // block RAM; only control state and registered outputs are reset.
    always_ff @(posedge clk) begin
        if (cap_we) mem[a_addr] <= in_data;
        if (hb_en && hb_we && !(cap_we && a_addr == hb_addr)) mem[hb_addr] <= hb_din;
        ram_a_q <= mem[a_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     hb_dout <= '0;
        else if (hb_en) hb_dout <= mem[hb_addr];
    end

endmodule

// File: tb/tb_frame_buf_replay.sv
// Self-checking bench for frame_buf_replay: randomized frames and handshakes compared
// against a behavioural model of RAM contents and replay order.
module tb_frame_buf_replay;
    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int GRP   = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          mode = 1'b0, in_sof = 1'b0, in_eof = 1'b0, in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_last, ovf, busy;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data, hb_dout;
    logic [AW:0]   frame_len;
    logic          hb_en = 1'b0, hb_we = 1'b0;
    logic [AW-1:0] hb_addr = '0;
    logic [DW-1:0] hb_din = '0;

    int tests_run = 0, tests_failed = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] frm [$];
    int exp_len = 0;
    bit exp_ovf = 1'b0, exp_mode = 1'b0;
    int last_span = 0;

    frame_buf_replay #(.DW(DW), .AW(AW), .GRP(GRP)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_sof(in_sof), .in_eof(in_eof),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .frame_len(frame_len), .ovf(ovf), .busy(busy),
        .hb_en(hb_en), .hb_we(hb_we), .hb_addr(hb_addr), .hb_din(hb_din), .hb_dout(hb_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Address of replay beat i, straight from the group-reversal rule.
    function automatic int exp_addr(input int i, input int len, input bit md);
        int g, k, n;
        if (!md) return i;
        g = i / GRP;
        k = i % GRP;
        n = (len - g * GRP < GRP) ? len - g * GRP : GRP;
        return g * GRP + n - 1 - k;
    endfunction

    // Drives frm as one frame; optional host write colliding with capture beat 'collide'.
    task automatic send_frame(input bit md, input int collide);
        int n = frm.size();
        mode = md;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sof   = (i == 0);
            in_eof   = (i == n - 1);
            in_data  = frm[i];
            if (i == collide) begin
                hb_en = 1'b1; hb_we = 1'b1; hb_addr = AW'(i); hb_din = ~frm[i];
            end
            @(posedge clk); #1;
            hb_en = 1'b0; hb_we = 1'b0;
            if (i < DEPTH) ref_mem[i] = frm[i];
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        exp_len  = (n < DEPTH) ? n : DEPTH;
        exp_ovf  = (n > DEPTH);
        exp_mode = md;
    endtask

    task automatic check_capture(input string tag);
        tests_run++;
        if (frame_len !== (AW+1)'(exp_len) || ovf !== exp_ovf) begin
            tests_failed++;
            $display("FAIL %s_capture: frame_len=%0d ovf=%b, required frame_len=%0d ovf=%b",
                     tag, frame_len, ovf, exp_len, exp_ovf);
        end
    endtask

    // bp: 0 = always ready, 1 = pattern 1,0,0,1,0,1, 2 = random. junk drives random in_* beats.
    task automatic collect(input int bp, input bit junk, input string tag);
        int idx = 0, cyc = 0, first = -1, last_cyc = -1;
        bit stalled = 1'b0;
        bit [5:0] pat = 6'b101001;
        logic [DW-1:0] held_d = '0, exp_d;
        logic held_l = 1'b0;
        while (idx < exp_len && cyc < 400) begin
            case (bp)
                0:       out_ready = 1'b1;
                1:       out_ready = pat[cyc % 6];
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (junk) begin
                in_valid = ($urandom_range(0, 1) == 1);
                in_sof   = ($urandom_range(0, 1) == 1);
                in_eof   = ($urandom_range(0, 1) == 1);
                in_data  = DW'($urandom);
            end
            if (stalled) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_last !== held_l) begin
                    tests_failed++;
                    $display("FAIL %s_stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             tag, out_valid, out_data, out_last, held_d, held_l);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                exp_d = ref_mem[exp_addr(idx, exp_len, exp_mode)];
                tests_run++;
                if (out_data !== exp_d || out_last !== (idx == exp_len - 1)) begin
                    tests_failed++;
                    $display("FAIL %s_beat%0d: data=%h last=%b, required data=%h last=%b",
                             tag, idx, out_data, out_last, exp_d, (idx == exp_len - 1));
                end
                if (first < 0) first = cyc;
                last_cyc = cyc;
                idx++;
            end
            stalled = (out_valid === 1'b1) && !out_ready;
            held_d  = out_data;
            held_l  = out_last;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        last_span = last_cyc - first + 1;
        tests_run++;
        if (idx != exp_len) begin
            tests_failed++;
            $display("FAIL %s_beat_count: got %0d beats, required %0d", tag, idx, exp_len);
        end
        tests_run++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_end_idle: busy=%b in_ready=%b out_valid=%b, required 0 1 0",
                     tag, busy, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b out_last=%b busy=%b, required 1 0 0 0",
                     in_ready, out_valid, out_last, busy);
        end
        tests_run++;
        if (out_data !== '0 || frame_len !== '0 || ovf !== 1'b0 || hb_dout !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: out_data=%h frame_len=%0d ovf=%b hb_dout=%h, required 0 0 0 0",
                     out_data, frame_len, ovf, hb_dout);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_forward();
        frm = {};
        for (int i = 0; i < 6; i++) frm.push_back(8'h10 + 8'(i));
        out_ready = 1'b1;
        send_frame(1'b0, -1);
        check_capture("fwd");
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL fwd_replay_entry: out_valid=%b in_ready=%b busy=%b, required 0 0 1",
                     out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL fwd_latency1: out_valid=%b, required 0", out_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL fwd_latency2: out_valid=%b, required 1", out_valid);
        end
        collect(0, 1'b0, "fwd");
        tests_run++;
        if (last_span != 6) begin
            tests_failed++;
            $display("FAIL fwd_continuous: span=%0d cycles, required 6", last_span);
        end
    endtask

    task automatic test_group_reverse();
        frm = {};
        for (int i = 0; i < 8; i++) frm.push_back(8'h01 + 8'(i));
        out_ready = 1'b1;
        send_frame(1'b1, -1);
        check_capture("grp");
        collect(0, 1'b0, "grp");
    endtask

    task automatic test_backpressure();
        frm = {};
        for (int i = 0; i < 6; i++) frm.push_back(8'h10 + 8'(i));
        out_ready = 1'b0;
        send_frame(1'b0, -1);
        collect(1, 1'b0, "bp_fwd");
        send_frame(1'b1, -1);
        collect(1, 1'b0, "bp_grp");
    endtask

    task automatic test_overflow();
        frm = {};
        for (int i = 0; i < 10; i++) frm.push_back(8'h20 + 8'(i));
        out_ready = 1'b1;
        send_frame(1'b0, -1);
        check_capture("ovf");
        collect(2, 1'b0, "ovf");
        in_valid = 1'b1; in_sof = 1'b1; in_data = 8'h5A;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
        tests_run++;
        if (ovf !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_clear_on_sof: ovf=%b busy=%b, required 0 1", ovf, busy);
        end
        @(posedge clk); #1;
        in_valid = 1'b1; in_eof = 1'b1; in_data = 8'hC3;
        @(posedge clk); #1;
        in_valid = 1'b0; in_eof = 1'b0;
        ref_mem[0] = 8'h5A; ref_mem[1] = 8'hC3;
        exp_len = 2; exp_ovf = 1'b0; exp_mode = 1'b0;
        check_capture("ovf_next");
        collect(0, 1'b0, "ovf_next");
    endtask

    task automatic test_host();
        int a;
        frm = {};
        for (int i = 0; i < 6; i++) frm.push_back(8'h10 + 8'(i));
        out_ready = 1'b1;
        send_frame(1'b0, 3);
        collect(0, 1'b0, "host_frame");
        hb_en = 1'b1; hb_we = 1'b0; hb_addr = 3'd2;
        @(posedge clk); #1;
        tests_run++;
        if (hb_dout !== 8'h12) begin
            tests_failed++;
            $display("FAIL host_read2: hb_dout=%h, required 12", hb_dout);
        end
        hb_en = 1'b0; hb_addr = 3'd5;
        @(posedge clk); #1;
        tests_run++;
        if (hb_dout !== 8'h12) begin
            tests_failed++;
            $display("FAIL host_hold: hb_dout=%h, required 12", hb_dout);
        end
        hb_en = 1'b1; hb_we = 1'b1; hb_din = 8'hA5;
        @(posedge clk); #1;
        tests_run++;
        if (hb_dout !== ref_mem[5]) begin
            tests_failed++;
            $display("FAIL host_read_first: hb_dout=%h, required %h", hb_dout, ref_mem[5]);
        end
        ref_mem[5] = 8'hA5;
        hb_we = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (hb_dout !== 8'hA5) begin
            tests_failed++;
            $display("FAIL host_write_read: hb_dout=%h, required a5", hb_dout);
        end
        hb_addr = 3'd3;
        @(posedge clk); #1;
        tests_run++;
        if (hb_dout !== 8'h13) begin
            tests_failed++;
            $display("FAIL host_collision: hb_dout=%h, required 13", hb_dout);
        end
        for (int r = 0; r < 6; r++) begin
            a = $urandom_range(0, DEPTH - 1);
            hb_addr = AW'(a);
            @(posedge clk); #1;
            tests_run++;
            if (hb_dout !== ref_mem[a]) begin
                tests_failed++;
                $display("FAIL host_rand_read%0d: addr=%0d hb_dout=%h, required %h", r, a, hb_dout, ref_mem[a]);
            end
        end
        hb_en = 1'b0;
    endtask

    task automatic test_reset_mid_replay();
        int seen = 0, guard = 0;
        bit stray = 1'b0;
        frm = {};
        for (int i = 0; i < 6; i++) frm.push_back(DW'($urandom));
        out_ready = 1'b1;
        send_frame(1'b0, -1);
        while (seen < 3 && guard < 50) begin
            if (out_valid === 1'b1) seen++;
            @(posedge clk); #1;
            guard++;
        end
        tests_run++;
        if (seen != 3) begin
            tests_failed++;
            $display("FAIL rstmid_reach_beat3: saw %0d beats, required 3", seen);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 || frame_len !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_abort: out_valid=%b busy=%b in_ready=%b out_last=%b frame_len=%0d, required 0 0 1 0 0",
                     out_valid, busy, in_ready, out_last, frame_len);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        tests_run++;
        if (stray) begin
            tests_failed++;
            $display("FAIL rstmid_no_valid: out_valid seen after reset, required none");
        end
        frm = {};
        for (int i = 0; i < 7; i++) frm.push_back(DW'($urandom));
        send_frame(1'b1, -1);
        check_capture("rstmid_next");
        collect(2, 1'b0, "rstmid_next");
    endtask

    task automatic test_random();
        int n;
        bit md;
        for (int r = 0; r < 12; r++) begin
            n  = $urandom_range(1, 12);
            md = ($urandom_range(0, 1) == 1);
            frm = {};
            for (int i = 0; i < n; i++) frm.push_back(DW'($urandom));
            out_ready = 1'b0;
            send_frame(md, -1);
            check_capture($sformatf("rand%0d", r));
            collect($urandom_range(0, 2), 1'b1, $sformatf("rand%0d", r));
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_group_reverse();
        test_backpressure();
        test_overflow();
        test_host();
        test_reset_mid_replay();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
